// File: rtl/banco_registros_sb_if.sv
// Bus between decode/issue, the writeback paths and banco_registros_sb:
// two read ports with busy flags, the issue handshake, two write ports
// and the pending-reservation count.
interface banco_registros_sb_if #(
  parameter int N    = 32,
  parameter int Bits = 64
);
  localparam int AW = $clog2(N);

  logic [AW-1:0]   ptr_rd_1;
  logic [AW-1:0]   ptr_rd_2;
  logic [Bits-1:0] data_rd_1;
  logic [Bits-1:0] data_rd_2;
  logic            busy_rd_1;
  logic            busy_rd_2;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            iss_ready;
  logic            wr_en_a;
  logic            wr_en_b;
  logic [AW-1:0]   ptr_wr_a;
  logic [AW-1:0]   ptr_wr_b;
  logic [Bits-1:0] data_wr_a;
  logic [Bits-1:0] data_wr_b;
  logic [AW:0]     pend_cnt;

  // Core side: drives pointers, issue requests and writebacks.
  modport master (
    output ptr_rd_1, ptr_rd_2, iss_valid, iss_rd,
    output wr_en_a, wr_en_b, ptr_wr_a, ptr_wr_b, data_wr_a, data_wr_b,
    input  data_rd_1, data_rd_2, busy_rd_1, busy_rd_2, iss_ready, pend_cnt
  );

  // Register-file side.
  modport slave (
    input  ptr_rd_1, ptr_rd_2, iss_valid, iss_rd,
    input  wr_en_a, wr_en_b, ptr_wr_a, ptr_wr_b, data_wr_a, data_wr_b,
    output data_rd_1, data_rd_2, busy_rd_1, busy_rd_2, iss_ready, pend_cnt
  );
endinterface

// File: rtl/banco_registros_sb.sv
// Two-write-port register file with a per-register scoreboard.
// x0 reads zero and is never busy; port B (load) wins write collisions.
// Optional feature: define BANCO_BYPASS_EN to forward same-cycle write
// data (and busy=0) onto matching read ports.
module banco_registros_sb #(
  parameter int N    = 32,
  parameter int Bits = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  banco_registros_sb_if.slave   bus
);
  localparam int AW = $clog2(N);

  logic [Bits-1:0] regs_r [1:N-1];
  logic [Bits-1:0] view_s [N];
  logic [N-1:0]    busy_r;
  logic [N-1:0]    busy_next_s;
  logic [AW:0]     pend_cnt_r;
  logic [AW:0]     pend_next_s;
  logic            iss_ready_s;
  logic            set_s;
  logic            clr_a_s;
  logic            clr_b_s;
  logic            wa_s;
  logic            wb_s;
  logic [Bits:0]   rd_1_s;
  logic [Bits:0]   rd_2_s;

  // Read-side view of storage with register 0 tied to zero.
  always_comb begin
    view_s[0] = '0;
    for (int i = 1; i < N; i++) begin
      view_s[i] = regs_r[i];
    end
  end

  // Returns {busy, data} for one read pointer.
  function automatic logic [Bits:0] read_port(input logic [AW-1:0] ptr);
    logic [Bits:0] res;
    res = {busy_r[ptr], view_s[ptr]};
`ifdef BANCO_BYPASS_EN
    if (wb_s && (bus.ptr_wr_b == ptr)) begin
      res = {1'b0, bus.data_wr_b};
    end else if (wa_s && (bus.ptr_wr_a == ptr)) begin
      res = {1'b0, bus.data_wr_a};
    end else begin
      res = res;
    end
`endif
    return res;
  endfunction

  // Qualified writes, issue acceptance and scoreboard next state.
  always_comb begin
    wa_s        = bus.wr_en_a && (bus.ptr_wr_a != '0);
    wb_s        = bus.wr_en_b && (bus.ptr_wr_b != '0);
    iss_ready_s = bus.iss_valid && ((bus.iss_rd == '0) || !busy_r[bus.iss_rd]);
    set_s       = iss_ready_s && (bus.iss_rd != '0);
    clr_a_s     = wa_s && busy_r[bus.ptr_wr_a];
    // A shared pointer with port A clears only one busy bit.
    clr_b_s     = wb_s && busy_r[bus.ptr_wr_b] &&
                  !(clr_a_s && (bus.ptr_wr_a == bus.ptr_wr_b));
    busy_next_s = busy_r;
    if (wa_s) begin
      busy_next_s[bus.ptr_wr_a] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (wb_s) begin
      busy_next_s[bus.ptr_wr_b] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    // Reservation wins over a same-cycle writeback to a free register.
    if (set_s) begin
      busy_next_s[bus.iss_rd] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
    busy_next_s[0] = 1'b0;
    pend_next_s = pend_cnt_r + (AW+1)'(set_s) - (AW+1)'(clr_a_s) - (AW+1)'(clr_b_s);
  end

  // Read ports, optionally with write forwarding.
  always_comb begin
    rd_1_s = read_port(bus.ptr_rd_1);
    rd_2_s = read_port(bus.ptr_rd_2);
  end

  // Register storage; port B overrides port A on the same pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < N; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 1; i < N; i++) begin
        if (wb_s && (bus.ptr_wr_b == AW'(i))) begin
          regs_r[i] <= bus.data_wr_b;
        end else if (wa_s && (bus.ptr_wr_a == AW'(i))) begin
          regs_r[i] <= bus.data_wr_a;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Scoreboard bits and pending-reservation count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r     <= '0;
      pend_cnt_r <= '0;
    end else begin
      busy_r     <= busy_next_s;
      pend_cnt_r <= pend_next_s;
    end
  end

  assign bus.data_rd_1 = rd_1_s[Bits-1:0];
  assign bus.busy_rd_1 = rd_1_s[Bits];
  assign bus.data_rd_2 = rd_2_s[Bits-1:0];
  assign bus.busy_rd_2 = rd_2_s[Bits];
  assign bus.iss_ready = iss_ready_s;
  assign bus.pend_cnt  = pend_cnt_r;
endmodule

// File: tb/tb_banco_registros_sb.sv
// Directed bench for banco_registros_sb with hand-computed expectations.
module tb_banco_registros_sb;
  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  banco_registros_sb_if #(.N(32), .Bits(64)) bus ();
  banco_registros_sb #(.N(32), .Bits(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 1'b0; bus.iss_rd = 5'd0;
    bus.wr_en_a = 1'b0; bus.wr_en_b = 1'b0;
    bus.ptr_wr_a = 5'd0; bus.ptr_wr_b = 5'd0;
    bus.data_wr_a = 64'h0; bus.data_wr_b = 64'h0;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    idle();
    bus.ptr_rd_1 = 5'd0; bus.ptr_rd_2 = 5'd0;
    rst = 1'b1;
    #1;
    // Reset state on every pointer.
    for (int i = 0; i < 32; i++) begin
      bus.ptr_rd_1 = 5'(i);
      bus.ptr_rd_2 = 5'(31 - i);
      #1;
      check("rst_data1", bus.data_rd_1, 64'h0);
      check("rst_data2", bus.data_rd_2, 64'h0);
      check("rst_busy1", {63'h0, bus.busy_rd_1}, 64'h0);
      check("rst_busy2", {63'h0, bus.busy_rd_2}, 64'h0);
    end
    check("rst_pend", {58'h0, bus.pend_cnt}, 64'h0);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5; #1;
    check("rst_iss_ready", {63'h0, bus.iss_ready}, 64'h1);
    idle();
    @(negedge clk);
    rst = 1'b0;

    // Dual write to distinct registers.
    bus.wr_en_a = 1'b1; bus.ptr_wr_a = 5'd5; bus.data_wr_a = 64'h1111;
    bus.wr_en_b = 1'b1; bus.ptr_wr_b = 5'd9; bus.data_wr_b = 64'h2222;
    bus.ptr_rd_1 = 5'd5; bus.ptr_rd_2 = 5'd9; #1;
`ifdef BANCO_BYPASS_EN
    check("byp_r5", bus.data_rd_1, 64'h1111);
    check("byp_r9", bus.data_rd_2, 64'h2222);
`else
    check("nobyp_r5", bus.data_rd_1, 64'h0);
    check("nobyp_r9", bus.data_rd_2, 64'h0);
`endif
    tick(); idle(); #1;
    check("wr_r5", bus.data_rd_1, 64'h1111);
    check("wr_r9", bus.data_rd_2, 64'h2222);

    // Writes to r0 are dropped.
    bus.wr_en_a = 1'b1; bus.ptr_wr_a = 5'd0; bus.data_wr_a = 64'hFFFF;
    bus.ptr_rd_1 = 5'd0; bus.ptr_rd_2 = 5'd0; #1;
    check("r0_same_cycle", bus.data_rd_1, 64'h0);
    tick(); idle(); #1;
    check("r0_data1", bus.data_rd_1, 64'h0);
    check("r0_data2", bus.data_rd_2, 64'h0);
    check("r0_pend", {58'h0, bus.pend_cnt}, 64'h0);

    // Collision: port B wins.
    bus.wr_en_a = 1'b1; bus.ptr_wr_a = 5'd7; bus.data_wr_a = 64'hAAAA;
    bus.wr_en_b = 1'b1; bus.ptr_wr_b = 5'd7; bus.data_wr_b = 64'hBBBB;
    bus.ptr_rd_1 = 5'd7; bus.ptr_rd_2 = 5'd5; #1;
`ifdef BANCO_BYPASS_EN
    check("byp_coll_r7", bus.data_rd_1, 64'hBBBB);
`else
    check("nobyp_coll_r7", bus.data_rd_1, 64'h0);
`endif
    tick(); idle(); #1;
    check("coll_r7", bus.data_rd_1, 64'hBBBB);
    check("coll_r5_kept", bus.data_rd_2, 64'h1111);

    // Issue r3, WAW stall, writeback.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3; bus.ptr_rd_1 = 5'd3; #1;
    check("iss_r3_ready", {63'h0, bus.iss_ready}, 64'h1);
    tick(); #1;
    check("iss_r3_busy", {63'h0, bus.busy_rd_1}, 64'h1);
    check("iss_r3_pend", {58'h0, bus.pend_cnt}, 64'h1);
    check("iss_r3_again", {63'h0, bus.iss_ready}, 64'h0);
    bus.wr_en_a = 1'b1; bus.ptr_wr_a = 5'd3; bus.data_wr_a = 64'h3333; #1;
    check("waw_no_credit", {63'h0, bus.iss_ready}, 64'h0);
`ifdef BANCO_BYPASS_EN
    check("byp_wb_busy", {63'h0, bus.busy_rd_1}, 64'h0);
`else
    check("nobyp_wb_busy", {63'h0, bus.busy_rd_1}, 64'h1);
`endif
    bus.iss_valid = 1'b0;
    tick(); idle(); #1;
    check("wb_r3_busy", {63'h0, bus.busy_rd_1}, 64'h0);
    check("wb_r3_data", bus.data_rd_1, 64'h3333);
    check("wb_r3_pend", {58'h0, bus.pend_cnt}, 64'h0);

    // Issue r4 while A writes free r4: set wins, data written.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    bus.wr_en_a = 1'b1; bus.ptr_wr_a = 5'd4; bus.data_wr_a = 64'h4444;
    bus.ptr_rd_1 = 5'd4; bus.ptr_rd_2 = 5'd4;
    tick(); idle(); #1;
    check("r4_data", bus.data_rd_1, 64'h4444);
    check("r4_busy", {63'h0, bus.busy_rd_2}, 64'h1);
    check("r4_pend", {58'h0, bus.pend_cnt}, 64'h1);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; #1;
    check("iss_r0_ready", {63'h0, bus.iss_ready}, 64'h1);
    tick(); idle(); #1;
    check("iss_r0_pend", {58'h0, bus.pend_cnt}, 64'h1);

    // Collision on a busy register clears it once.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    tick(); idle(); #1;
    check("r7_pend2", {58'h0, bus.pend_cnt}, 64'h2);
    bus.wr_en_a = 1'b1; bus.ptr_wr_a = 5'd7; bus.data_wr_a = 64'h7A;
    bus.wr_en_b = 1'b1; bus.ptr_wr_b = 5'd7; bus.data_wr_b = 64'h7B;
    tick(); idle(); #1;
    check("coll_clr_once", {58'h0, bus.pend_cnt}, 64'h1);
    bus.wr_en_b = 1'b1; bus.ptr_wr_b = 5'd4; bus.data_wr_b = 64'h44;
    tick(); idle(); #1;
    check("r4_clr_pend", {58'h0, bus.pend_cnt}, 64'h0);

    // Reserve r1..r31, then async reset mid-cycle.
    for (int i = 1; i < 32; i++) begin
      bus.iss_valid = 1'b1; bus.iss_rd = 5'(i);
      tick();
    end
    idle();
    bus.ptr_rd_1 = 5'd31; bus.ptr_rd_2 = 5'd9; #1;
    check("full_pend", {58'h0, bus.pend_cnt}, 64'd31);
    check("full_busy31", {63'h0, bus.busy_rd_1}, 64'h1);
    check("full_r9_data", bus.data_rd_2, 64'h2222);
    #1;
    rst = 1'b1; #1;
    check("arst_pend", {58'h0, bus.pend_cnt}, 64'h0);
    check("arst_busy", {63'h0, bus.busy_rd_1}, 64'h0);
    check("arst_data", bus.data_rd_2, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
